// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write lanes, NUM_RD read ports,
// write-to-read bypass, pending scoreboard and a sequential clear engine.
module regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    output logic                     ready_o,
    input  logic                     wr0_en_i,
    input  logic [ADDR_W-1:0]        wr0_addr_i,
    input  logic [DATA_W-1:0]        wr0_data_i,
    input  logic                     wr1_en_i,
    input  logic [ADDR_W-1:0]        wr1_addr_i,
    input  logic [DATA_W-1:0]        wr1_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_pend_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;

    logic run;
    logic wr0_ok, wr1_ok, rsv_ok;
    logic wr0_shadow;

    // Architecturally writable/readable: in range and not the zero register
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) &&
               !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign ready_o = (state_q == READY);
    assign run     = (state_q == READY) && !clr_i;

    assign wr0_ok = run && wr0_en_i && addr_ok(wr0_addr_i);
    assign wr1_ok = run && wr1_en_i && addr_ok(wr1_addr_i);
    assign rsv_ok = run && rsv_en_i && addr_ok(rsv_addr_i);

    // Lane 1 is younger, so it overwrites lane 0 on an address collision
    assign wr0_shadow = wr1_ok && (wr1_addr_i == wr0_addr_i);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            CLEAR: begin
                if (32'(clr_ptr_q) == 32'(NUM_REGS - 1)) begin
                    state_d = READY;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            READY: begin
                if (clr_i) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // A reservation is issued after the write it races, so it wins
    always_comb begin
        pend_d = pend_q;
        if ((state_q == READY) && clr_i) begin
            pend_d = '0;
        end else if (run) begin
            if (wr0_ok) pend_d[wr0_addr_i] = 1'b0;
            if (wr1_ok) pend_d[wr1_addr_i] = 1'b0;
            if (rsv_ok) pend_d[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Storage has no reset; the clear engine zeroes one entry per cycle
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else begin
            if (wr0_ok && !wr0_shadow) mem_q[wr0_addr_i] <= wr0_data_i;
            if (wr1_ok)                mem_q[wr1_addr_i] <= wr1_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              ok;
        logic              hit0, hit1, hit_rsv;
        logic [DATA_W-1:0] data;

        assign ra      = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign ok      = (state_q == READY) && addr_ok(ra);
        assign hit0    = wr0_en_i && (wr0_addr_i == ra);
        assign hit1    = wr1_en_i && (wr1_addr_i == ra);
        assign hit_rsv = rsv_en_i && (rsv_addr_i == ra);

        always_comb begin
            data = '0;
            if (ok) begin
                if (hit1) begin
                    data = wr1_data_i;
                end else if (hit0) begin
                    data = wr0_data_i;
                end else begin
                    data = mem_q[ra];
                end
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
        assign rd_pend_o[k] = ok &&
            (hit_rsv || (!hit0 && !hit1 && pend_q[ra]));
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes model predictions,
// a negedge monitor pops and compares against the DUT outputs.
module tb_regfile_mp;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;

    logic                     clk;
    logic                     rst;
    logic                     clr;
    logic                     ready;
    logic                     wr0_en, wr1_en, rsv_en;
    logic [ADDR_W-1:0]        wr0_addr, wr1_addr, rsv_addr;
    logic [DATA_W-1:0]        wr0_data, wr1_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;

    regfile_mp #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clr),
        .ready_o   (ready),
        .wr0_en_i  (wr0_en),
        .wr0_addr_i(wr0_addr),
        .wr0_data_i(wr0_data),
        .wr1_en_i  (wr1_en),
        .wr1_addr_i(wr1_addr),
        .wr1_data_i(wr1_data),
        .rsv_en_i  (rsv_en),
        .rsv_addr_i(rsv_addr),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .rd_pend_o (rd_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                     rdy;
        logic [NUM_RD*DATA_W-1:0] d;
        logic [NUM_RD-1:0]        p;
        int                       cyc;
    } exp_t;

    exp_t q[$];

    // Behavioural reference: whole-file state plus remaining clear cycles
    logic [DATA_W-1:0] m_mem [NUM_REGS];
    bit                m_pend[NUM_REGS];
    int                clr_left;
    int                cyc;
    int                ntests;
    int                nfail;

    function automatic bit valid_a(int a);
        return (a != 0) && (a < NUM_REGS);
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        clr_left = NUM_REGS;
    endtask

    task automatic push_exp();
        exp_t e;
        e.rdy = (clr_left == 0) && !rst;
        e.d   = '0;
        e.p   = '0;
        e.cyc = cyc;
        if (e.rdy) begin
            for (int k = 0; k < NUM_RD; k++) begin
                int a;
                bit h0, h1, hr;
                a  = int'(rd_addr[k*ADDR_W +: ADDR_W]);
                h0 = wr0_en && (int'(wr0_addr) == a);
                h1 = wr1_en && (int'(wr1_addr) == a);
                hr = rsv_en && (int'(rsv_addr) == a);
                if (valid_a(a)) begin
                    if (h1)      e.d[k*DATA_W +: DATA_W] = wr1_data;
                    else if (h0) e.d[k*DATA_W +: DATA_W] = wr0_data;
                    else         e.d[k*DATA_W +: DATA_W] = m_mem[a];
                    e.p[k] = hr ? 1'b1 : ((h0 || h1) ? 1'b0 : m_pend[a]);
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic model_edge();
        if (clr_left > 0) begin
            clr_left--;
        end else if (clr) begin
            model_wipe();
        end else begin
            if (wr0_en && valid_a(int'(wr0_addr))) begin
                m_mem[wr0_addr]  = wr0_data;
                m_pend[wr0_addr] = 1'b0;
            end
            if (wr1_en && valid_a(int'(wr1_addr))) begin
                m_mem[wr1_addr]  = wr1_data;
                m_pend[wr1_addr] = 1'b0;
            end
            if (rsv_en && valid_a(int'(rsv_addr))) m_pend[rsv_addr] = 1'b1;
        end
    endtask

    task automatic idle();
        clr = 0; wr0_en = 0; wr1_en = 0; rsv_en = 0;
        wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
        wr0_data = '0; wr1_data = '0;
    endtask

    task automatic set_rd(int k, int a);
        rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic step();
        push_exp();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_wipe();
        #1;
        push_exp();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic check_int(string name, int got, int want);
        ntests++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, want);
        end
    endtask

    // Counts clear edges until ready_o, bounded so a stuck DUT still ends
    task automatic wait_ready(string name, int start);
        int n;
        n = start;
        idle();
        while (!ready && n < 100) begin
            step();
            n++;
        end
        check_int(name, n, NUM_REGS);
    endtask

    task automatic rand_step();
        clr      = ($urandom_range(0, 149) == 0);
        wr0_en   = $urandom_range(0, 1) == 1;
        wr1_en   = $urandom_range(0, 2) == 0;
        rsv_en   = $urandom_range(0, 2) == 0;
        wr0_addr = ADDR_W'($urandom_range(0, 11));
        wr1_addr = ADDR_W'($urandom_range(0, 11));
        rsv_addr = ADDR_W'($urandom_range(0, 11));
        wr0_data = {$urandom(), $urandom()};
        wr1_data = {$urandom(), $urandom()};
        for (int k = 0; k < NUM_RD; k++) begin
            if ($urandom_range(0, 3) == 0) set_rd(k, $urandom_range(0, 31));
            else set_rd(k, $urandom_range(0, 11));
        end
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                ntests++;
                if (ready !== e.rdy) begin
                    nfail++;
                    $display("FAIL ready cyc=%0d got=%0b exp=%0b",
                             e.cyc, ready, e.rdy);
                end
                ntests++;
                if (rd_data !== e.d) begin
                    nfail++;
                    $display("FAIL rd_data cyc=%0d got=%h exp=%h",
                             e.cyc, rd_data, e.d);
                end
                ntests++;
                if (rd_pend !== e.p) begin
                    nfail++;
                    $display("FAIL rd_pend cyc=%0d got=%b exp=%b",
                             e.cyc, rd_pend, e.p);
                end
            end
        end
    end

    initial begin : stim
        ntests = 0;
        nfail  = 0;
        cyc    = 0;
        rst    = 1'b1;
        rd_addr = '0;
        idle();
        model_wipe();
        @(posedge clk);
        #1;
        do_reset();
        wait_ready("reset_clear_len", 1);
        for (int a = 0; a < NUM_REGS; a += 2) begin
            set_rd(0, a); set_rd(1, a + 1);
            step();
        end

        idle(); set_rd(0, 5); set_rd(1, 5);
        wr0_en = 1; wr0_addr = 5; wr0_data = 64'hDEAD;
        step();
        wr0_data = 64'h1;
        step();
        idle();
        step();

        wr0_en = 1; wr0_addr = 7; wr0_data = 64'hA;
        wr1_en = 1; wr1_addr = 7; wr1_data = 64'hB;
        set_rd(0, 7);
        step();
        idle();
        step();

        set_rd(1, 3);
        rsv_en = 1; rsv_addr = 3;
        step();
        idle();
        step();
        wr1_en = 1; wr1_addr = 3; wr1_data = 64'h33;
        step();
        idle();
        step();
        rsv_en = 1; rsv_addr = 3;
        wr0_en = 1; wr0_addr = 3; wr0_data = 64'h44;
        step();
        idle();
        step();

        set_rd(0, 0);
        wr0_en = 1; wr0_addr = 0; wr0_data = 64'hFFFF;
        rsv_en = 1; rsv_addr = 0;
        step();
        idle();
        step();

        set_rd(0, 9);
        wr0_en = 1; wr0_addr = 9; wr0_data = 64'h55;
        step();
        idle();
        step();
        clr = 1;
        step();
        wait_ready("soft_clear_len", 0);
        step();

        clr = 1;
        step();
        idle();
        repeat (10) rand_step();
        idle();
        do_reset();
        wait_ready("midclear_reset_len", 1);

        repeat (800) rand_step();
        idle();
        step();

        @(posedge clk);
        #1;
        check_int("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
